// File: rtl/bus_responder.sv
// bus_responder: single-outstanding CPU bus target. Decodes each request to
// an internal word RAM, an external IO port, or an error response, and
// completes it with a one-cycle bus_done pulse. bus_err accompanies bus_done
// on unmapped or timed-out accesses.
//
// Handshake: bus_start is a request strobe. It is sampled only while the
// responder is idle, so a request is accepted exactly at a rising edge where
// the FSM is in IDLE and bus_start = 1. Every accepted request produces
// exactly one bus_done pulse, and bus_q is valid in that cycle. The FSM is
// already back in IDLE during the bus_done cycle, so a new bus_start there is
// accepted. The IO side is a level request: io_req, io_we, io_addr and
// io_wdata are held stable until io_ack = 1 is sampled or the wait times out.
// dbg_state exposes the FSM state for observation.
module bus_responder #(
  parameter int RAM_ADDR_BITS = 10,
  parameter int IO_TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] bus_addr,
  input  logic [31:0] bus_data,
  input  logic        bus_we,
  input  logic        bus_start,
  output logic [31:0] bus_q,
  output logic        bus_done,
  output logic        bus_err,
  output logic        io_req,
  output logic        io_we,
  output logic [23:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic        io_ack,
  input  logic [31:0] io_rdata,
  output logic [1:0]  dbg_state
);

  localparam int RAM_WORDS = 1 << RAM_ADDR_BITS;
  // The wait counter value sampled at the last IO_WAIT edge before timeout.
  localparam logic [7:0] WAIT_LAST = 8'(IO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_ACC = 2'd1,
    IO_WAIT = 2'd2,
    ERR     = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       io_req_q, io_req_d;
  logic                       we_q, we_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [23:0]                io_addr_q, io_addr_d;
  logic [RAM_ADDR_BITS-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic                       ram_we;
  logic                       is_ram;
  logic                       is_io;

  // RAM contents are not reset; they survive reset.
  logic [31:0] mem [RAM_WORDS];

  assign is_ram = (bus_addr >> RAM_ADDR_BITS) == 27'd0;
  assign is_io  = bus_addr[26:24] == 3'b111;

  // Next-state, response data and IO request computation.
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    io_req_d   = io_req_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    io_addr_d  = io_addr_q;
    ram_addr_d = ram_addr_q;
    cnt_d      = cnt_q;
    ram_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_start) begin
          we_d       = bus_we;
          wdata_d    = bus_data;
          io_addr_d  = bus_addr[23:0];
          ram_addr_d = bus_addr[RAM_ADDR_BITS-1:0];
          if (is_ram) begin
            state_d = RAM_ACC;
          end else if (is_io) begin
            state_d  = IO_WAIT;
            io_req_d = 1'b1;
            cnt_d    = 8'd0;
          end else begin
            state_d = ERR;
          end
        end
      end
      RAM_ACC: begin
        if (we_q) begin
          ram_we = 1'b1;
        end else begin
          rdata_d = mem[ram_addr_q];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      IO_WAIT: begin
        // io_ack wins over a timeout landing on the same edge.
        if (io_ack) begin
          if (!we_q) begin
            rdata_d = io_rdata;
          end
          io_req_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          rdata_d  = 32'hFFFF_FFFF;
          io_req_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ERR: begin
        rdata_d = 32'd0;
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers; reset discards any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      io_req_q   <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      io_addr_q  <= 24'd0;
      ram_addr_q <= '0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      io_req_q   <= io_req_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      io_addr_q  <= io_addr_d;
      ram_addr_q <= ram_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  // RAM write port, committed at the RAM_ACC exit edge.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr_q] <= wdata_q;
    end
  end

  assign bus_q     = rdata_q;
  assign bus_done  = done_q;
  assign bus_err   = err_q;
  assign io_req    = io_req_q;
  assign io_we     = we_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_responder.sv
// Testbench for bus_responder: table-driven RAM/unmapped vectors plus
// hand-written IO, timeout and reset sequences, with a completion scoreboard.
module tb_bus_responder;

  logic        clk;
  logic        reset;
  logic [26:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_we;
  logic        bus_start;
  logic [31:0] bus_q;
  logic        bus_done;
  logic        bus_err;
  logic        io_req;
  logic        io_we;
  logic [23:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_ack;
  logic [31:0] io_rdata;
  logic [1:0]  dbg_state;

  bus_responder #(.RAM_ADDR_BITS(10), .IO_TIMEOUT(255)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .bus_we    (bus_we),
    .bus_start (bus_start),
    .bus_q     (bus_q),
    .bus_done  (bus_done),
    .bus_err   (bus_err),
    .io_req    (io_req),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_ack    (io_ack),
    .io_rdata  (io_rdata),
    .dbg_state (dbg_state)
  );

  // Clock / cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scoreboard: {err, data} and the cycle (as seen at negedge) of each done.
  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];

  typedef struct {
    logic [26:0] addr;
    logic        we;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a request at the current negedge and record its expected completion.
  task automatic issue(input logic [26:0] a, input logic we, input logic [31:0] d,
                       input logic exp_err, input logic [31:0] exp_data, input int lat);
    exp_q.push_back({exp_err, exp_data});
    exp_cyc_q.push_back(cyc + lat);
    bus_addr  = a;
    bus_we    = we;
    bus_data  = d;
    bus_start = 1'b1;
  endtask

  // Drop the strobe after the sampling edge, then wait for bus_done.
  task automatic wait_done(input int budget);
    @(negedge clk);
    bus_start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_done) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: no bus_done within %0d cycles (cycle %0d)", budget, cyc);
  endtask

  // Completion monitor: pops the scoreboard on each bus_done.
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    int          c;
    if (bus_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got bus_done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("done_data", bus_q, e[31:0]);
        check("done_err", 32'(bus_err), 32'(e[32]));
        check("done_cycle", 32'(cyc), 32'(c));
      end
    end else if (bus_err) begin
      checks++;
      errors++;
      $display("FAIL err_without_done: got bus_err=1 expected 0 (cycle %0d)", cyc);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          k;
    int          n;
    logic [26:0] a;
    logic [31:0] d;
    logic [31:0] prev_q;

    reset     = 1'b0;
    bus_addr  = '0;
    bus_data  = '0;
    bus_we    = 1'b0;
    bus_start = 1'b0;
    io_ack    = 1'b0;
    io_rdata  = '0;

    vecs[0]  = '{27'h000_0005, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{27'h000_0005, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{27'h000_0006, 1'b1, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{27'h000_03FF, 1'b1, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{27'h000_03FF, 1'b0, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[5]  = '{27'h040_0000, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[6]  = '{27'h000_0400, 1'b1, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[7]  = '{27'h000_0000, 1'b1, 32'h0123_4567, 32'h0000_0000, 1'b0};
    vecs[8]  = '{27'h000_0000, 1'b0, 32'h0,         32'h0123_4567, 1'b0};
    vecs[9]  = '{27'h6FF_FFFF, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[10] = '{27'h000_0006, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b0};

    // Outputs forced low while reset is asserted, before any clock edge.
    #2;
    check("rst_bus_q", bus_q, 32'h0);
    check("rst_bus_done", 32'(bus_done), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_io_req", 32'(io_req), 32'h0);
    check("rst_io_we", 32'(io_we), 32'h0);
    check("rst_io_addr", 32'(io_addr), 32'h0);
    check("rst_io_wdata", io_wdata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // RAM and unmapped vectors; each new request issued in the done cycle.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].addr, vecs[i].we, vecs[i].data, vecs[i].exp_err, vecs[i].exp_data, 2);
      wait_done(10);
    end

    // Back-to-back reads: done pulses exactly 2 cycles apart.
    issue(27'h005, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);
    wait_done(10);
    issue(27'h006, 1'b0, 32'h0, 1'b0, 32'hCAFE_F00D, 2);
    wait_done(10);
    prev_q = 32'hCAFE_F00D;

    // Random RAM write/read pairs.
    for (int i = 0; i < 6; i++) begin
      a = 27'($urandom_range(16, 1023));
      d = $urandom;
      issue(a, 1'b1, d, 1'b0, prev_q, 2);
      wait_done(10);
      issue(a, 1'b0, 32'h0, 1'b0, d, 2);
      wait_done(10);
      prev_q = d;
    end

    // IO read, io_ack during the third io_req cycle; bus_start held into
    // IO_WAIT with a different address must be ignored.
    k = cyc;
    issue(27'h700_0010, 1'b0, 32'h0, 1'b0, 32'h1234_5678, 4);
    @(negedge clk);
    n = 0;
    check("io_rd_req", 32'(io_req), 32'h1);
    check("io_rd_addr", 32'(io_addr), 32'h0000_0010);
    check("io_rd_we", 32'(io_we), 32'h0);
    if (io_req) n++;
    bus_addr = 27'h005;
    @(negedge clk);
    bus_start = 1'b0;
    check("io_rd_addr_hold", 32'(io_addr), 32'h0000_0010);
    if (io_req) n++;
    @(negedge clk);
    if (io_req) n++;
    io_ack   = 1'b1;
    io_rdata = 32'h1234_5678;
    @(negedge clk);
    io_ack   = 1'b0;
    io_rdata = 32'h0;
    check("io_rd_req_drop", 32'(io_req), 32'h0);
    check("io_rd_req_cycles", 32'(n), 32'd3);
    check("io_rd_latency", 32'(cyc - k), 32'd4);

    // IO write: bus_q keeps the previous read value.
    issue(27'h7AB_CDEF, 1'b1, 32'h55AA_55AA, 1'b0, 32'h1234_5678, 2);
    @(negedge clk);
    bus_start = 1'b0;
    check("io_wr_we", 32'(io_we), 32'h1);
    check("io_wr_addr", 32'(io_addr), 32'h00AB_CDEF);
    check("io_wr_wdata", io_wdata, 32'h55AA_55AA);
    io_ack   = 1'b1;
    io_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    io_ack   = 1'b0;
    io_rdata = 32'h0;

    // IO timeout: 255 IO_WAIT cycles, then error completion.
    issue(27'h700_0020, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 256);
    @(negedge clk);
    bus_start = 1'b0;
    n = 0;
    for (int i = 0; i < 300 && !bus_done; i++) begin
      if (io_req) n++;
      @(negedge clk);
    end
    check("to_req_cycles", 32'(n), 32'd255);
    check("to_req_drop", 32'(io_req), 32'h0);

    // io_ack on the timeout edge: normal completion.
    issue(27'h700_0030, 1'b0, 32'h0, 1'b0, 32'hA0A0_A0A0, 256);
    @(negedge clk);
    bus_start = 1'b0;
    repeat (254) @(negedge clk);
    io_ack   = 1'b1;
    io_rdata = 32'hA0A0_A0A0;
    @(negedge clk);
    io_ack   = 1'b0;
    io_rdata = 32'h0;
    check("to_ack_err", 32'(bus_err), 32'h0);
    check("to_ack_req_drop", 32'(io_req), 32'h0);

    // Reset in the middle of IO_WAIT: no completion, io_req drops at once.
    bus_addr  = 27'h700_0040;
    bus_we    = 1'b0;
    bus_start = 1'b1;
    @(negedge clk);
    bus_start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_req_high", 32'(io_req), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_req", 32'(io_req), 32'h0);
    check("mid_rst_done", 32'(bus_done), 32'h0);
    check("mid_rst_q", bus_q, 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // RAM contents survive reset.
    issue(27'h005, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);
    wait_done(10);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
